aes256_enc_core: RTL and testbench
==================================

Name: aes256_enc_core

Overview:
- Iterative AES-256 encryption engine with a fixed 256-bit key and a two-register host interface.
- A control register is written when `addr`=0.
- A plaintext write with `addr`=1 starts one encryption, which runs one AES round per clock.
- The 128-bit ciphertext is presented on `encData` with a `done` level.

Parameters:
- N, 16, number of bytes in the data ports (fixed at 16; other values unsupported).
- NFLAGS, 8, width of the `flags` port.
- KEY, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, AES-256 cipher key (FIPS-197 byte order, MSB = key byte 0).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  asynchronous reset, active-high despite the name; while 1, all registers are held at their reset values.
- plaintext  in  [N-1:0][7:0]  write data. `plaintext[15]` = AES input byte 0, `plaintext[0]` = byte 15.
- addr  in  1  register select: 0 = control register, 1 = plaintext/start.
- flags  in  NFLAGS  reserved; sampled by nothing; must not affect any output.
- encData  out  [N-1:0][7:0]  ciphertext, same byte order as `plaintext`.
- done  out  1  ciphertext valid level.

Behaviour:
- Reset values: `ctrl`=8'h00, FSM=IDLE, `encData`=0, `done`=0, state and round-key registers=0, round counter=0.
- Control register:
  - In IDLE with `addr`=0, `ctrl` is loaded with `plaintext[0]` (bits 7:0) every cycle.
  - `ctrl[0]` = enable; `ctrl[7:1]` are stored but have no effect.
  - Writes are ignored outside IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when `addr`=1 and `ctrl[0]`=1. On that edge:
  - state <= `plaintext` XOR `KEY[255:128]` (round-key 0);
  - round counter <= 1.
- IDLE with `addr`=1 and `ctrl[0]`=0: no action.
- RUN:
  - Each edge applies round r (r=1..14): SubBytes, ShiftRows, MixColumns (omitted when r=14), AddRoundKey(r).
  - Round keys are generated on the fly by the standard AES-256 key expansion: Nk=8, Rcon applied every 8 words, SubWord-only on word index i mod 8 = 4.
  - Plaintext changes during RUN are ignored.
  - After round 14: `encData` <= final state and `done` <= 1, then go to DONE.
- Latency: `done` rises on the 15th rising edge after the start edge.
- DONE:
  - `done`=1 and `encData` are held stable.
  - Go to IDLE on the first edge where `addr`=0; `done` <= 0 on that edge; `encData` keeps its value.
  - This blocks re-triggering while `addr` is held at 1.
- A new start requires `addr` to drop to 0 and return to 1 with `ctrl[0]`=1. With `addr`=0 in IDLE, the control write happens as normal.
- Reset mid-operation: asserting `resetn` at any time aborts immediately and restores all reset values; no partial ciphertext becomes visible.
- XOR/GF(2^8) arithmetic: xtime with reduction polynomial 0x11B.
- No multicycle or combinational path from inputs to outputs.

Decomposition:
- Package `aes256_pkg`:
  - constants NR=14, NK=8, N=16;
  - Rcon table (01,02,04,08,10,20,40);
  - typedefs `aes_state_t` ([15:0][7:0]) and `aes_word_t` ([31:0]);
  - functions xtime, ShiftRows, MixColumns.
- One sub-module `aes_sbox`: combinational 256-entry forward S-box, byte in/out.
  - 16 instances for SubBytes.
  - 4 instances for SubWord in the key schedule.

Test Plan:
- Reset: drive `resetn`=1 for 2 cycles -> `encData`=0, `done`=0. Release to 0 -> outputs remain 0 with `addr`=1 and `ctrl`=0.
- FIPS-197 C.3:
  - stimulus: `addr`=0, `plaintext`=1; then `addr`=1, `plaintext`=128'h00112233445566778899aabbccddeeff;
  - required: `done`=1 exactly 15 edges after the start edge and `encData`=128'h8ea2b7ca516745bfeafc49904b496089.
- Disabled: `ctrl`=0 (write `plaintext`=0 with `addr`=0), then `addr`=1 for 30 cycles -> `done` never asserts.
- Hold/re-arm:
  - keep `addr`=1 after `done` -> `done` stays 1 and `encData` stable for 20 cycles;
  - `addr`=0 then 1 with `plaintext`=128'h00000101030307070f0f1f1f3f3f7f7f -> `done` after 15 edges, `encData` equal to the software AES-256 model under KEY.
- Abort: assert `resetn` during round 7 of the C.3 vector -> `done`=0 and `encData`=0. A subsequent full run still yields 8ea2b7ca516745bfeafc49904b496089.
- `flags` sweep: repeat C.3 with `flags`=8'hFF and with `flags`=8'h00 -> identical `encData` and identical `done` timing.

Source files
------------

// File: rtl/aes256_pkg.sv
// Shared types, constants and round-function helpers for the iterative AES-256 encryptor.
// Byte b of the AES state (column-major, b = 4*col + row) lives at packed index 15-b.
package aes256_pkg;

    localparam int NR = 14;
    localparam int NK = 8;
    localparam int N  = 16;

    typedef logic [15:0][7:0] aes_state_t;
    typedef logic [31:0]      aes_word_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} aes_fsm_t;

    // Entry 7 pads the table so a 3-bit index never reads past the end.
    localparam logic [7:0] RCON [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h00};

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t t;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[15 - (4*c + r)] = s[15 - (4*((c + r) % 4) + r)];
            end
        end
        return t;
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s);
        aes_state_t t;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[15 - 4*c];
            a1 = s[14 - 4*c];
            a2 = s[13 - 4*c];
            a3 = s[12 - 4*c];
            t[15 - 4*c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            t[14 - 4*c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            t[13 - 4*c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            t[12 - 4*c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return t;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: one byte in, its substitution out.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Entry 0x00 sits in the top byte, so the lookup offset is (255 - a) * 8.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes256_enc_core.sv
// Iterative AES-256 encryptor: one round per clock, round keys expanded on the fly
// from a sliding eight-word window of the key schedule.
module aes256_enc_core
    import aes256_pkg::*;
#(
    parameter int           N      = 16,
    parameter int           NFLAGS = 8,
    parameter logic [255:0] KEY    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [N-1:0][7:0] plaintext,
    input  logic              addr,
    input  logic [NFLAGS-1:0] flags,
    output logic [N-1:0][7:0] encData,
    output logic              done
);

    localparam logic [3:0] LAST_RND = 4'(NR);
    localparam logic [3:0] FIN_RND  = 4'(NR + 1);

    aes_fsm_t     fsm_q, fsm_d;
    aes_state_t   st_q, sb, sr, mc, round_out;
    logic [255:0] key_q, key_next;
    logic [3:0]   rnd_q, rnd_m1;
    logic [7:0]   ctrl_q;
    aes_word_t    sub_word, sched_t, n0, n1, n2, n3;

    logic unused_ok;
    assign unused_ok = ^{flags, ctrl_q[7:1]};

    for (genvar i = 0; i < 16; i++) begin : g_subbytes
        aes_sbox u_sbox (.a(st_q[i]), .y(sb[i]));
    end

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (.a(key_q[8*i +: 8]), .y(sub_word[8*i +: 8]));
    end

    assign sr        = shift_rows(sb);
    assign mc        = mix_columns(sr);
    assign round_out = ((rnd_q == LAST_RND) ? sr : mc) ^ key_q[127:0];

    // Window holds w[4(r-1) .. 4(r-1)+7]; the next four words start at i = 4r+4,
    // which is a RotWord+Rcon step for odd r and a plain SubWord step for even r.
    assign rnd_m1   = rnd_q - 4'd1;
    assign sched_t  = rnd_q[0] ? ({sub_word[23:0], sub_word[31:24]} ^ {RCON[rnd_m1[3:1]], 24'h0})
                               : sub_word;
    assign n0       = key_q[255:224] ^ sched_t;
    assign n1       = key_q[223:192] ^ n0;
    assign n2       = key_q[191:160] ^ n1;
    assign n3       = key_q[159:128] ^ n2;
    assign key_next = {key_q[127:0], n0, n1, n2, n3};

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) fsm_q <= IDLE;
        else        fsm_q <= fsm_d;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves fsm_d unassigned (no latch).
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (addr && ctrl_q[0]) fsm_d = RUN;
            RUN:     if (rnd_q == FIN_RND)  fsm_d = DONE;
            DONE:    if (!addr)             fsm_d = IDLE;
            default:                        fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            ctrl_q  <= 8'h00;
            st_q    <= '0;
            key_q   <= '0;
            rnd_q   <= 4'd0;
            encData <= '0;
            done    <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (!addr) begin
                        ctrl_q <= plaintext[0];
                    end else if (ctrl_q[0]) begin
                        st_q  <= plaintext ^ KEY[255:128];
                        key_q <= KEY;
                        rnd_q <= 4'd1;
                    end
                end
                RUN: begin
                    if (rnd_q == FIN_RND) begin
                        encData <= st_q;
                        done    <= 1'b1;
                    end else begin
                        st_q  <= round_out;
                        key_q <= key_next;
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                DONE: if (!addr) done <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes256_enc_core.sv
// Directed bench for aes256_enc_core: FIPS-197 C.3 vector, hold/re-arm, disable, abort and flags cases.
module tb_aes256_enc_core;

    localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_C3 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_2  = 128'h00000101030307070f0f1f1f3f3f7f7f;

    logic         clk;
    logic         resetn;
    logic [127:0] plaintext;
    logic         addr;
    logic [7:0]   flags;
    logic [127:0] encData;
    logic         done;

    int           n_vec;
    int           n_err;
    int           lat;
    int           cnt;
    logic [127:0] exp2;

    aes256_enc_core dut (
        .clk       (clk),
        .resetn    (resetn),
        .plaintext (plaintext),
        .addr      (addr),
        .flags     (flags),
        .encData   (encData),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference S-box derived algebraically (GF(2^8) inverse plus affine map).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        if (x == 8'h00) r = 8'h00;
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
    endfunction

    function automatic logic [127:0] aes256_ref(input logic [127:0] pt, input logic [255:0] key);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] out;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++) s[4*c + k] = s[4*c + k] ^ w[c][31 - 8*k -: 8];
        for (int r = 1; r <= 14; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_ref(s[i]);
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < 4; k++) t[k + 4*c] = s[k + 4*((c + k) % 4)];
            for (int c = 0; c < 4; c++) begin
                if (r < 14) begin
                    s[4*c+0] = gmul(t[4*c+0], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c+0] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c+0] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c+0], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int k = 0; k < 4; k++) s[4*c + k] = t[4*c + k];
                end
                for (int k = 0; k < 4; k++) s[4*c + k] = s[4*c + k] ^ w[4*r + c][31 - 8*k -: 8];
            end
        end
        for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
        return out;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Arms ctrl[0] from IDLE or DONE, then issues the start write; returns just after the start edge.
    task automatic start_enc(input logic [127:0] pt, input logic [7:0] fl);
        flags     = fl;
        addr      = 1'b0;
        plaintext = 128'h1;
        repeat (2) @(negedge clk);
        addr      = 1'b1;
        plaintext = pt;
        @(negedge clk);
        plaintext = ~pt;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < 40) begin
            @(negedge clk);
            edges++;
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        resetn    = 1'b1;
        addr      = 1'b0;
        plaintext = '0;
        flags     = 8'h00;

        repeat (2) @(negedge clk);
        check("reset_enc", encData, 128'h0);
        check("reset_done", 128'(done), 128'h0);

        addr      = 1'b1;
        plaintext = PT_C3;
        resetn    = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_enc", encData, 128'h0);
        check("idle_done", 128'(done), 128'h0);

        start_enc(PT_C3, 8'h00);
        wait_done(lat);
        check("c3_latency", 128'(lat), 128'd15);
        check("c3_ct", encData, CT_C3);

        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1 && encData === CT_C3) cnt++;
        end
        check("hold_stable_cycles", 128'(cnt), 128'd20);

        exp2 = aes256_ref(PT_2, KEY_C);
        start_enc(PT_2, 8'h00);
        wait_done(lat);
        check("rearm_latency", 128'(lat), 128'd15);
        check("rearm_ct", encData, exp2);

        addr      = 1'b0;
        plaintext = '0;
        repeat (2) @(negedge clk);
        addr = 1'b1;
        cnt  = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done !== 1'b0) cnt++;
        end
        check("disabled_done_cycles", 128'(cnt), 128'd0);

        start_enc(PT_C3, 8'h00);
        repeat (6) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("abort_done", 128'(done), 128'h0);
        check("abort_enc", encData, 128'h0);
        resetn = 1'b0;
        start_enc(PT_C3, 8'h00);
        wait_done(lat);
        check("post_abort_latency", 128'(lat), 128'd15);
        check("post_abort_ct", encData, CT_C3);

        start_enc(PT_C3, 8'hFF);
        wait_done(lat);
        check("flags_ff_latency", 128'(lat), 128'd15);
        check("flags_ff_ct", encData, CT_C3);
        start_enc(PT_C3, 8'h00);
        wait_done(lat);
        check("flags_00_latency", 128'(lat), 128'd15);
        check("flags_00_ct", encData, CT_C3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
